// File: rtl/tspp_lsu_split_if.sv
// Load/store splitter interface: request, response and bus sides.
// The LSU uses the slave modport; the requester/bus model uses master.
interface tspp_lsu_split_if #(
  parameter int XLEN = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [XLEN-1:0]   req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_mal;
  logic              resp_fault;
  logic              flush;
  logic              bus_ren;
  logic              bus_wen;
  logic [XLEN-1:0]   bus_addr;
  logic [XLEN/8-1:0] bus_byte_en;
  logic [XLEN-1:0]   bus_wdata;
  logic [XLEN-1:0]   bus_rdata;
  logic              bus_busy;
  logic              bus_fault;

  modport slave (
    input  req_valid, req_wen, req_addr, req_size,
    input  req_unsigned, req_wdata, flush,
    input  bus_rdata, bus_busy, bus_fault,
    output req_ready, resp_valid, resp_rdata,
    output resp_mal, resp_fault,
    output bus_ren, bus_wen, bus_addr,
    output bus_byte_en, bus_wdata
  );

  modport master (
    output req_valid, req_wen, req_addr, req_size,
    output req_unsigned, req_wdata, flush,
    output bus_rdata, bus_busy, bus_fault,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_mal, resp_fault,
    input  bus_ren, bus_wen, bus_addr,
    input  bus_byte_en, bus_wdata
  );
endinterface

// File: rtl/tspp_lsu_split.sv
// LSU access splitter: turns a byte-addressed load/store into one or
// two XLEN-aligned bus beats and assembles/extends the load result.
module tspp_lsu_split #(
  parameter int XLEN             = 32,
  parameter int SPLIT_MISALIGNED = 1
) (
  input logic            CLK,
  input logic            RST,
  tspp_lsu_split_if.slave io
);
  localparam int BYTES = XLEN / 8;
  localparam int OFFW  = $clog2(BYTES);

  typedef enum logic [1:0] {
    IDLE,
    BEAT1,
    BEAT2,
    RESP
  } state_e;

  state_e          state_q, state_d;
  logic            wen_q, wen_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            cross_q, cross_d;
  logic            mal_q, mal_d;
  logic            fault_q, fault_d;
  logic            abort_q, abort_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] hi_q, hi_d;

  logic [OFFW-1:0] in_off;
  logic [3:0]      in_n;
  logic            in_cross;
  logic            in_mis;
  logic            in_bad;
  logic            in_rej;

  // Classify the incoming request so the accept edge picks the path
  always_comb begin
    in_off   = io.req_addr[OFFW-1:0];
    in_n     = 4'd1 << io.req_size;
    in_cross = (5'(in_off) + 5'(in_n)) > 5'(BYTES);
    in_mis   = (io.req_addr[2:0] & 3'(in_n - 4'd1)) != 3'd0;
    in_bad   = (XLEN == 32) && (io.req_size == 2'd3);
    in_rej   = in_bad || (in_mis && (SPLIT_MISALIGNED == 0));
  end

  logic [OFFW-1:0]    off;
  logic [3:0]         nb;
  logic [XLEN-1:0]    line_addr;
  logic [2*BYTES-1:0] be_wide;
  logic [2*XLEN-1:0]  wd_wide;
  logic [2*XLEN-1:0]  rd_wide;
  logic [XLEN-1:0]    rd_sh;
  logic [XLEN-1:0]    mask;
  logic               sbit;
  logic [XLEN-1:0]    ext;

  // Lanes/data past the line end spill into the upper half for beat 2
  always_comb begin
    off       = addr_q[OFFW-1:0];
    nb        = 4'd1 << size_q;
    line_addr = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
    be_wide   = ((2*BYTES)'(1) << nb) - (2*BYTES)'(1);
    be_wide   = be_wide << off;
    wd_wide   = {{XLEN{1'b0}}, wdata_q} << {off, 3'b000};
    rd_wide   = {hi_q, lo_q} >> {off, 3'b000};
    rd_sh     = rd_wide[XLEN-1:0];
    mask      = ~({XLEN{1'b1}} << {nb, 3'b000});
    sbit      = |(rd_sh & mask & ~(mask >> 1));
    if (!uns_q && sbit) ext = rd_sh | ~mask;
    else                ext = rd_sh & mask;
  end

  logic abort_now;

  always_comb begin
    state_d   = state_q;
    wen_d     = wen_q;
    addr_d    = addr_q;
    size_d    = size_q;
    uns_d     = uns_q;
    wdata_d   = wdata_q;
    cross_d   = cross_q;
    mal_d     = mal_q;
    fault_d   = fault_q;
    abort_d   = abort_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    abort_now = abort_q | io.flush;
    unique case (state_q)
      IDLE: begin
        if (io.req_valid) begin
          wen_d   = io.req_wen;
          addr_d  = io.req_addr;
          size_d  = io.req_size;
          uns_d   = io.req_unsigned;
          wdata_d = io.req_wdata;
          cross_d = in_cross & ~in_rej;
          mal_d   = in_rej;
          fault_d = 1'b0;
          abort_d = 1'b0;
          lo_d    = '0;
          hi_d    = '0;
          state_d = in_rej ? RESP : BEAT1;
        end
      end
      BEAT1: begin
        abort_d = abort_now;
        if (!io.bus_busy) begin
          lo_d = io.bus_rdata;
          if (abort_now) begin
            abort_d = 1'b0;
            state_d = IDLE;
          end else if (io.bus_fault) begin
            fault_d = 1'b1;
            state_d = RESP;
          end else if (cross_q) begin
            state_d = BEAT2;
          end else begin
            state_d = RESP;
          end
        end
      end
      BEAT2: begin
        abort_d = abort_now;
        if (!io.bus_busy) begin
          hi_d = io.bus_rdata;
          if (abort_now) begin
            abort_d = 1'b0;
            state_d = IDLE;
          end else begin
            fault_d = io.bus_fault;
            state_d = RESP;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      cross_q <= 1'b0;
      mal_q   <= 1'b0;
      fault_q <= 1'b0;
      abort_q <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      cross_q <= cross_d;
      mal_q   <= mal_d;
      fault_q <= fault_d;
      abort_q <= abort_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  logic in_beat;
  logic second;
  logic in_resp;

  always_comb begin
    in_beat = (state_q == BEAT1) || (state_q == BEAT2);
    second  = (state_q == BEAT2);
    in_resp = (state_q == RESP);
  end

  assign io.req_ready   = (state_q == IDLE);
  assign io.bus_ren     = in_beat & ~wen_q;
  assign io.bus_wen     = in_beat & wen_q;
  assign io.bus_addr    = second ? line_addr + XLEN'(BYTES)
                                 : line_addr;
  assign io.bus_byte_en = second ? be_wide[2*BYTES-1:BYTES]
                                 : be_wide[BYTES-1:0];
  assign io.bus_wdata   = second ? wd_wide[2*XLEN-1:XLEN]
                                 : wd_wide[XLEN-1:0];
  assign io.resp_valid  = in_resp;
  assign io.resp_mal    = in_resp & mal_q;
  assign io.resp_fault  = in_resp & fault_q;
  assign io.resp_rdata  =
    (in_resp && !wen_q && !mal_q && !fault_q) ? ext : '0;
endmodule
